seq_detector_prog: RTL and testbench
====================================

// Module: seq_detector_prog
// PURPOSE
//  Runtime-programmable serial bit-sequence detector; successor to the fixed 1011 detector.
//  Pattern (1..MAX_LEN bits), length and overlap mode are loaded through a config port.
//  Emits a 1-cycle match pulse and a saturating match count.
//  Sits on a serial input stream qualified by in_valid.
// PARAMETERS
//  MAX_LEN  16  max pattern length in bits (>=2)
//  CNT_W    16  width of match_count
// PORTS
//  clk          in   1              clock, all logic on posedge
//  rstn         in   1              reset, synchronous, active-low
//  cfg_we       in   1              load cfg_pattern/cfg_len/cfg_overlap this cycle
//  cfg_pattern  in   MAX_LEN        pattern; bit [len-1] is the FIRST bit received
//  cfg_len      in   $clog2(MAX_LEN+1)  pattern length; 0 = detector disabled
//  cfg_overlap  in   1              1 = overlapping matches, 0 = non-overlapping
//  in_valid     in   1              in_bit is valid this cycle
//  in_bit       in   1              serial data bit
//  count_clr    in   1              clear match_count
//  match        out  1              1-cycle pulse, registered
//  match_count  out  CNT_W          matches since reset/clear, saturates at all-ones
//  armed        out  1              fill >= len and len != 0
// BEHAVIOUR
//  - Reset: pattern=4'b1011 (zero-extended), len=4, overlap=1, hist=0, fill=0,
//    match=0, match_count=0, armed=0.
//  - hist: MAX_LEN-bit shift reg; on accepted bit hist <= {hist[MAX_LEN-2:0], in_bit}.
//  - fill: bits received since last flush, saturates at MAX_LEN.
//  - Bit accepted when in_valid && !cfg_we. Idle cycles (in_valid=0) hold all state.
//  - Hit: accepted bit, len!=0, fill+1 >= len, hist_next[len-1:0] == pattern[len-1:0].
//  - Latency: match=1 in the cycle after the clock edge that samples the last bit
//    (same timing as the fixed 1011 detector); match=0 otherwise.
//  - Overlap=1: fill unchanged on hit (1011011 -> 2 hits for 1011).
//    Overlap=0: fill <= 0 on hit; next hit needs len fresh bits (1011011 -> 1 hit).
//  - cfg_len > MAX_LEN is clamped to MAX_LEN at load; pattern bits >= len are ignored.
//  - cfg_we: load config, fill <= 0, hist <= 0, match <= 0; in_bit that cycle is dropped.
//  - match_count: +1 per hit, sticks at 2^CNT_W-1.
//    count_clr and hit in the same cycle -> count=1; count_clr alone -> 0.
//  - rstn low mid-stream: all state returns to reset values on that edge; partial
//    sequences are discarded.
//  - armed: combinational from registered fill/len.
// STRUCTURE
//  - Package seq_det_pkg: LEN_W = $clog2(MAX_LEN+1); RST_PATTERN=4'b1011, RST_LEN=4.
//  - Package also holds function len_mask(len) -> MAX_LEN-bit mask of len ones.
//  - Sub-module sat_counter #(CNT_W): inc, clr, q; clr+inc -> 1; saturates.
//  - Top: config regs, hist/fill regs, masked compare, match reg.
// TESTING
//  1. Reset defaults, stream 1,0,1,1 -> match 1 cycle after 4th bit; count=1.
//  2. Overlap=1, len=4, pat=1011, stream 1011011 -> 2 pulses; count=2.
//     Overlap=0, same stream -> 1 pulse.
//  3. Load pat=16'hA5C3, len=16; feed A5C3 MSB-first with in_valid gaps -> 1 pulse.
//     Gaps do not break the match. 15-bit prefix alone -> none.
//  4. len=1, pat=1, overlap=1, stream 1,1,0,1 -> 3 pulses.
//     len=0 -> never a match, armed=0.
//  5. CNT_W=4: 20 hits -> count sticks at 15.
//     count_clr on a hit cycle -> count=1.
//  6. cfg_we mid-pattern (after 101) with in_valid=1 -> that bit dropped, fill=0.
//     rstn low after 101 -> 1 after reset gives no match.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable sequence detector.
package seq_det_pkg;

    // Default pattern capacity and the width needed to hold a length 0..MAX_LEN
    localparam int MAX_LEN_DEF = 16;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

    // Power-up configuration reproduces the legacy fixed 1011 detector
    localparam logic [3:0] RST_PATTERN = 4'b1011;
    localparam int         RST_LEN     = 4;

    // Widest mask the helper can build; callers slice down to their MAX_LEN
    localparam int unsigned MASK_MAX = 64;

    // Mask with the low 'len' bits set
    function automatic logic [MASK_MAX-1:0] len_mask(input int unsigned len);
        logic [MASK_MAX-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < MASK_MAX; i++) begin
            mask[i] = (i < len);
        end
        return mask;
    endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;

    // Count events, stick at all-ones, clear takes priority over the held value
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-sequence detector with saturating match counter.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           cfg_we,
    input  logic [MAX_LEN-1:0]             cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]   cfg_len,
    input  logic                           cfg_overlap,
    input  logic                           in_valid,
    input  logic                           in_bit,
    input  logic                           count_clr,
    output logic                           match,
    output logic [CNT_W-1:0]               match_count,
    output logic                           armed
);

    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0]  pattern_q;
    logic [LW-1:0]       len_q;
    logic                overlap_q;
    logic [MAX_LEN-1:0]  hist_q;
    logic [LW-1:0]       fill_q;
    logic                match_q;

    logic                accept;
    logic [MAX_LEN-1:0]  hist_next;
    logic [LW:0]         fill_inc;
    logic [MASK_MAX-1:0] mask_full;
    logic [MAX_LEN-1:0]  mask;
    logic                pat_eq;
    logic                len_nz;
    logic                fill_sat;
    logic                hit;
    logic [LW-1:0]       cfg_len_clamped;

    // Hit detection: the incoming bit completes the pattern over the last len bits
    always_comb begin
        accept          = in_valid && !cfg_we;
        hist_next       = {hist_q[MAX_LEN-2:0], in_bit};
        fill_inc        = {1'b0, fill_q} + (LW+1)'(1);
        mask_full       = len_mask(32'(len_q));
        mask            = mask_full[MAX_LEN-1:0];
        pat_eq          = ((hist_next ^ pattern_q) & mask) == '0;
        len_nz          = (len_q != '0);
        fill_sat        = (fill_q == LW'(MAX_LEN));
        hit             = accept && len_nz && (fill_inc >= {1'b0, len_q}) && pat_eq;
        cfg_len_clamped = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
    end

    // Config load flushes history; accepted bits shift in and advance the fill level
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pattern_q <= MAX_LEN'(RST_PATTERN);
            len_q     <= LW'(RST_LEN);
            overlap_q <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len_clamped;
            overlap_q <= cfg_overlap;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            match_q <= hit;
            if (accept) begin
                hist_q <= hist_next;
                // Non-overlapping mode demands len fresh bits before the next hit
                if (hit && !overlap_q) begin
                    fill_q <= '0;
                end else if (!fill_sat) begin
                    fill_q <= fill_q + LW'(1);
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (hit),
        .clr  (count_clr),
        .q    (match_count)
    );

    assign match = match_q;
    assign armed = len_nz && (fill_q >= len_q);

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed-vector bench for seq_detector_prog (MAX_LEN=16, CNT_W=4).
module tb_seq_detector_prog;

    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 4;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pattern = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_overlap = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_bit = 1'b0;
    logic               count_clr = 1'b0;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               armed;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    seq_detector_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .count_clr   (count_clr),
        .match       (match),
        .match_count (match_count),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive at negedge, sample 1 time unit after the rising edge
    task automatic cycle(input logic v, input logic b, input logic we, input logic clr);
        @(negedge clk);
        in_valid  = v;
        in_bit    = b;
        cfg_we    = we;
        count_clr = clr;
        @(posedge clk);
        #1;
        if (match === 1'b1) pulses++;
    endtask

    task automatic load_cfg(input logic [MAX_LEN-1:0] pat, input logic [LW-1:0] len, input logic ovl);
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Send the n low bits of w, MSB first, optionally with an idle cycle after each bit
    task automatic send_word(input logic [31:0] w, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            cycle(1'b1, w[i], 1'b0, 1'b0);
            if (gaps) cycle(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clear_count();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        pulses = 0;
    endtask

    initial begin
        // Reset defaults
        rstn = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rst_match", match, 0);
        check_eq("rst_count", match_count, 0);
        check_eq("rst_armed", armed, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Default 1011 detector, exact latency
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t1_no_early", match, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t1_match", match, 1);
        check_eq("t1_armed", armed, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t1_pulse_1cyc", match, 0);
        check_eq("t1_count", match_count, 1);

        // Overlapping vs non-overlapping on 1011011
        load_cfg(16'b1011, 5'd4, 1'b1);
        clear_count();
        send_word(32'b1011011, 7, 1'b0);
        check_eq("t2_ovl_pulses", pulses, 2);
        check_eq("t2_ovl_count", match_count, 2);
        load_cfg(16'b1011, 5'd4, 1'b0);
        clear_count();
        send_word(32'b1011011, 7, 1'b0);
        check_eq("t2_novl_pulses", pulses, 1);
        check_eq("t2_novl_count", match_count, 1);

        // Full-length pattern with gaps, then a 15-bit prefix alone
        load_cfg(16'hA5C3, 5'd16, 1'b1);
        clear_count();
        send_word(32'hA5C3, 16, 1'b1);
        check_eq("t3_full_pulses", pulses, 1);
        check_eq("t3_full_armed", armed, 1);
        load_cfg(16'hA5C3, 5'd16, 1'b1);
        clear_count();
        send_word(32'hA5C3 >> 1, 15, 1'b0);
        check_eq("t3_prefix_pulses", pulses, 0);
        check_eq("t3_prefix_armed", armed, 0);

        // Length above MAX_LEN is clamped to 16
        load_cfg(16'hA5C3, 5'd31, 1'b1);
        clear_count();
        send_word(32'hA5C3, 16, 1'b0);
        check_eq("t3_clamp_pulses", pulses, 1);

        // Single-bit pattern, then disabled detector
        load_cfg(16'h0001, 5'd1, 1'b1);
        clear_count();
        send_word(32'b1101, 4, 1'b0);
        check_eq("t4_len1_pulses", pulses, 3);
        load_cfg(16'b1011, 5'd0, 1'b1);
        clear_count();
        send_word(32'b1011_1011_1111_0000, 16, 1'b0);
        check_eq("t4_len0_pulses", pulses, 0);
        check_eq("t4_len0_armed", armed, 0);
        check_eq("t4_len0_count", match_count, 0);

        // Counter saturation and clear interaction
        load_cfg(16'h0001, 5'd1, 1'b1);
        clear_count();
        send_word(32'hFFFFF, 20, 1'b0);
        check_eq("t5_sat_pulses", pulses, 20);
        check_eq("t5_sat_count", match_count, 15);
        cycle(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("t5_clr_hit_count", match_count, 1);
        check_eq("t5_clr_hit_match", match, 1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t5_clr_only", match_count, 0);

        // Config write mid-pattern drops that bit and flushes history
        load_cfg(16'b1011, 5'd4, 1'b1);
        clear_count();
        send_word(32'b101, 3, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("t6_we_match", match, 0);
        check_eq("t6_we_armed", armed, 0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t6_we_no_hit", match, 0);
        check_eq("t6_we_count", match_count, 0);

        // Reset mid-pattern discards partial sequence
        send_word(32'b101, 3, 1'b0);
        @(negedge clk);
        rstn = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("t6_rst_armed", armed, 0);
        @(negedge clk);
        rstn = 1'b1;
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("t6_rst_no_hit", match, 0);
        check_eq("t6_rst_count", match_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
